// File: rtl/scan_pkg.sv
// Shared constants and FSM state encoding for the truth-table scanner.
package scan_pkg;

  localparam int unsigned N_IN_DEF     = 3;
  localparam int unsigned TABLE_W_DEF  = 8;
  localparam int unsigned TICK_DIV_DEF = 4;
  localparam int unsigned TICK_W       = 8;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    SCAN = 2'd1,
    DONE = 2'd2
  } scan_state_e;

endpackage

// File: rtl/scan_tick_timer.sv
// Settle-interval counter: expire is high on the cycle the count reaches TICK_DIV-1.
module scan_tick_timer
  import scan_pkg::*;
#(
  parameter int unsigned TICK_DIV = TICK_DIV_DEF
) (
  input  logic clk,
  input  logic rst_n,
  input  logic clear,
  input  logic enable,
  output logic expire
);

  logic [TICK_W-1:0] count;

  assign expire = enable && (count == TICK_W'(TICK_DIV - 1));

  always_ff @(posedge clk) begin
    if (!rst_n || clear) begin
      count <= '0;
    end else if (enable) begin
      count <= expire ? '0 : count + TICK_W'(1);
    end
  end

endmodule

// File: rtl/truth_table_scanner.sv
// Walks a 3-input FUT through all minterms, captures f per minterm and counts ones.
// Optional SCAN_COMPARE_EN adds exp_table/match for an on-chip table compare.
module truth_table_scanner
  import scan_pkg::*;
#(
  parameter  int unsigned N_IN     = N_IN_DEF,
  parameter  int unsigned TICK_DIV = TICK_DIV_DEF,
  localparam int unsigned TABLE_W  = 2 ** N_IN
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               start,
  output logic [N_IN-1:0]    xyz,
  input  logic               f_in,
`ifdef SCAN_COMPARE_EN
  input  logic [TABLE_W-1:0] exp_table,
  output logic               match,
`endif
  output logic               busy,
  output logic               done,
  output logic [TABLE_W-1:0] table_o,
  output logic [N_IN:0]      ones_cnt
);

  localparam int unsigned CNT_W = N_IN + 1;

  scan_state_e        state;
  logic [N_IN-1:0]    idx;
  logic               expire;
  logic               launch;
  logic [TABLE_W-1:0] table_next;

  assign xyz    = idx;
  assign launch = (state == IDLE) && start;

  scan_tick_timer #(.TICK_DIV(TICK_DIV)) u_timer (
    .clk    (clk),
    .rst_n  (rst_n),
    .clear  (launch),
    .enable (state == SCAN),
    .expire (expire)
  );

  // Captured table including the bit sampled on this edge.
  always_comb begin
    table_next      = table_o;
    table_next[idx] = f_in;
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state    <= IDLE;
      idx      <= '0;
      busy     <= 1'b0;
      done     <= 1'b0;
      table_o  <= '0;
      ones_cnt <= '0;
`ifdef SCAN_COMPARE_EN
      match    <= 1'b0;
`endif
    end else begin
      case (state)
        IDLE: begin
          done <= 1'b0;
          if (start) begin
            state    <= SCAN;
            idx      <= '0;
            busy     <= 1'b1;
            table_o  <= '0;
            ones_cnt <= '0;
`ifdef SCAN_COMPARE_EN
            match    <= 1'b0;
`endif
          end
        end
        SCAN: begin
          if (expire) begin
            table_o  <= table_next;
            ones_cnt <= ones_cnt + CNT_W'(f_in);
            if (idx == N_IN'(TABLE_W - 1)) begin
              state <= DONE;
              busy  <= 1'b0;
              done  <= 1'b1;
`ifdef SCAN_COMPARE_EN
              match <= (table_next == exp_table);
`endif
            end else begin
              idx <= idx + N_IN'(1);
            end
          end
        end
        DONE: begin
          done  <= 1'b0;
          state <= IDLE;
        end
        default: begin
          state <= IDLE;
          busy  <= 1'b0;
          done  <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_truth_table_scanner.sv
// Directed bench: one scanner with TICK_DIV=4 and one with TICK_DIV=1, each driving a modelled FUT.
module tb_truth_table_scanner;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       start4, start1;
  logic [2:0] xyz4, xyz1;
  logic       f4, f1;
  logic       busy4, busy1, done4, done1;
  logic [7:0] table4, table1;
  logic [3:0] ones4, ones1;
  int         mode4, mode1;
  int         checks = 0;
  int         failures = 0;
`ifdef SCAN_COMPARE_EN
  logic [7:0] exp4, exp1;
  logic       match4, match1;
`endif

  always #5 clk = ~clk;

  // FUT models: 0 -> f=0, 1 -> x~y | ~yz | xz | xy~z, 2 -> f=z, 3 -> f=1
  function automatic logic fut(input int mode, input logic [2:0] v);
    logic x, y, z;
    x = v[2]; y = v[1]; z = v[0];
    case (mode)
      1:       return (x & ~y) | (~y & z) | (x & z) | (x & y & ~z);
      2:       return z;
      3:       return 1'b1;
      default: return 1'b0;
    endcase
  endfunction

  assign f4 = fut(mode4, xyz4);
  assign f1 = fut(mode1, xyz1);

  truth_table_scanner #(.N_IN(3), .TICK_DIV(4)) u4 (
    .clk      (clk),
    .rst_n    (rst_n),
    .start    (start4),
    .xyz      (xyz4),
    .f_in     (f4),
`ifdef SCAN_COMPARE_EN
    .exp_table(exp4),
    .match    (match4),
`endif
    .busy     (busy4),
    .done     (done4),
    .table_o  (table4),
    .ones_cnt (ones4)
  );

  truth_table_scanner #(.N_IN(3), .TICK_DIV(1)) u1 (
    .clk      (clk),
    .rst_n    (rst_n),
    .start    (start1),
    .xyz      (xyz1),
    .f_in     (f1),
`ifdef SCAN_COMPARE_EN
    .exp_table(exp1),
    .match    (match1),
`endif
    .busy     (busy1),
    .done     (done1),
    .table_o  (table1),
    .ones_cnt (ones1)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Called just after start edge E0; returns edges from E0 to done and busy-high cycles.
  task automatic wait_done4(output int n, output int b);
    n = 0;
    b = (busy4 === 1'b1) ? 1 : 0;
    while (done4 !== 1'b1 && n < 100) begin
      step();
      n++;
      if (busy4 === 1'b1) b++;
    end
  endtask

  int n, b;

  initial begin
    rst_n = 1'b0; start4 = 1'b0; start1 = 1'b0;
    mode4 = 1; mode1 = 2;
`ifdef SCAN_COMPARE_EN
    exp4 = 8'hF2; exp1 = 8'h00;
`endif

    // 1. reset state
    repeat (3) step();
    check("rst_xyz",   32'(xyz4),   32'h0);
    check("rst_busy",  32'(busy4),  32'h0);
    check("rst_done",  32'(done4),  32'h0);
    check("rst_table", 32'(table4), 32'h00);
    check("rst_ones",  32'(ones4),  32'h0);
    check("rst_busy1", 32'(busy1),  32'h0);
    rst_n = 1'b1;
    step();

    // 2. nominal scan, TICK_DIV=4
    start4 = 1'b1;
    step();
    start4 = 1'b0;
    check("s2_busy_e0", 32'(busy4), 32'h1);
    check("s2_xyz_e0",  32'(xyz4),  32'h0);
    wait_done4(n, b);
    check("s2_latency", 32'(n), 32'd32);
    check("s2_busycyc", 32'(b), 32'd32);
    check("s2_table",   32'(table4), 32'hF2);
    check("s2_ones",    32'(ones4),  32'd5);
    check("s2_busy_dn", 32'(busy4),  32'h0);
    check("s2_xyz_dn",  32'(xyz4),   32'h7);
    step();
    check("s2_done_pulse", 32'(done4), 32'h0);
    repeat (3) step();
    check("s2_hold_table", 32'(table4), 32'hF2);
    check("s2_hold_ones",  32'(ones4),  32'd5);

    // 3. TICK_DIV=1, f=z: one minterm per cycle
    start1 = 1'b1;
    step();
    start1 = 1'b0;
    check("s3_xyz0", 32'(xyz1), 32'h0);
    for (int k = 1; k < 8; k++) begin
      step();
      check($sformatf("s3_xyz%0d", k), 32'(xyz1), 32'(k));
    end
    check("s3_notdone", 32'(done1), 32'h0);
    step();
    check("s3_done",  32'(done1),  32'h1);
    check("s3_table", 32'(table1), 32'hAA);
    check("s3_ones",  32'(ones1),  32'd4);

    // 4. start held high, f=1: back-to-back scans
    mode4 = 3;
    start4 = 1'b1;
    step();
    wait_done4(n, b);
    check("s4a_latency", 32'(n), 32'd32);
    check("s4a_table",   32'(table4), 32'hFF);
    check("s4a_ones",    32'(ones4),  32'd8);
    step();
    check("s4_idle_busy",  32'(busy4),  32'h0);
    check("s4_idle_done",  32'(done4),  32'h0);
    check("s4_idle_table", 32'(table4), 32'hFF);
    step();
    check("s4_relaunch_busy",  32'(busy4),  32'h1);
    check("s4_relaunch_table", 32'(table4), 32'h00);
    wait_done4(n, b);
    check("s4b_latency", 32'(n), 32'd32);
    check("s4b_table",   32'(table4), 32'hFF);
    check("s4b_ones",    32'(ones4),  32'd8);
    start4 = 1'b0;
    repeat (2) step();
    check("s4_stop_busy", 32'(busy4), 32'h0);

    // 5. reset mid-scan at idx=3
    mode4 = 1;
    start4 = 1'b1;
    step();
    start4 = 1'b0;
    repeat (12) step();
    check("s5_idx3", 32'(xyz4), 32'h3);
    rst_n = 1'b0;
    step();
    check("s5_rst_xyz",   32'(xyz4),   32'h0);
    check("s5_rst_busy",  32'(busy4),  32'h0);
    check("s5_rst_done",  32'(done4),  32'h0);
    check("s5_rst_table", 32'(table4), 32'h00);
    check("s5_rst_ones",  32'(ones4),  32'h0);
    rst_n = 1'b1;
    step();
    check("s5_idle_busy", 32'(busy4), 32'h0);
    start4 = 1'b1;
    step();
    start4 = 1'b0;
    wait_done4(n, b);
    check("s5_latency", 32'(n), 32'd32);
    check("s5_table",   32'(table4), 32'hF2);
    check("s5_ones",    32'(ones4),  32'd5);

`ifdef SCAN_COMPARE_EN
    // 6. on-chip compare against exp_table = F2
    check("s6_match_hit", 32'(match4), 32'h1);
    step();
    mode4 = 0;
    start4 = 1'b1;
    step();
    start4 = 1'b0;
    check("s6_match_clr", 32'(match4), 32'h0);
    wait_done4(n, b);
    check("s6_match_miss", 32'(match4), 32'h0);
    check("s6_ones",       32'(ones4),  32'h0);
    check("s6_table",      32'(table4), 32'h00);
`endif

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
